if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage (initiator) of the 5-stage MIPS pipeline.
- Owns the PC and drives the address into the combinational instruction ROM, which answers in the same cycle.
- Registers the returned word into the IF/ID pipeline register.
- Applies stall, flush and redirect from downstream stages, detects the program-end self-jump, and counts fetched instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_DETECT, 1, enables self-jump halt detection (0 = never halt).
- NOP_WORD, 32'h00000000, instruction word inserted as a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to the instruction ROM; always equals the PC.
- imem_instr  in  32  instruction word from the ROM, valid in the same cycle as imem_addr.
- stall  in  1  hazard unit holds the PC and IF/ID.
- id_redirect  in  1  the ID stage resolved a j/jal/jr.
- id_target  in  32  target for id_redirect.
- ex_redirect  in  1  the EX stage resolved a taken branch.
- ex_target  in  32  target for ex_redirect.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  sticky flag: program-end self-jump detected.
- fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (asynchronous, reset=0):
  - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, halted=0, fetch_count=0.
  - Deassertion takes effect at the next rising edge.
- imem_addr = pc (combinational, no added latency). Fetch latency is one cycle from the PC update to the IF/ID update.
- Per rising edge, first matching rule wins:
  1. halted=1: pc holds; IF/ID loads bubble (NOP_WORD, valid=0); all redirects and stalls are ignored.
  2. ex_redirect=1: pc<=ex_target; IF/ID<=bubble. Overrides stall, because the stalling instruction is younger than the branch. Overrides id_redirect.
  3. stall=1: pc and IF/ID hold. A simultaneous id_redirect is dropped; ID re-presents it after the stall.
  4. id_redirect=1: pc<=id_target; IF/ID<=bubble.
  5. Otherwise: pc<=pc+4 (32-bit wrap, carry discarded); ifid_instr<=imem_instr; ifid_pc4<=pc+4; ifid_valid<=1; fetch_count<=fetch_count+1 (wraps at 2^32).
- fetch_count increments only under rule 5.
- Targets are used as given. Bits [1:0] of targets are not checked; the ROM ignores them.
- Halt detection (HALT_DETECT=1), evaluated only under rule 5 on imem_instr:
  - Condition: opcode[31:26]==6'b000010 AND {pc[31:28], imem_instr[25:0], 2'b00}==pc.
  - The word is still latched into IF/ID with valid=1, and pc<=pc+4 as normal.
  - halted<=1 from the next edge. From then on rule 1 applies and fetch stops.
  - halted clears only on reset.
- A jal self-jump (opcode 000011) does not halt.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; no pending redirect survives.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_J=6'b000010, OP_JAL=6'b000011;
  - NOP_WORD;
  - a function computing the jump target {pc4[31:28], idx26, 2'b00}. pc[31:28] is used for halt detection, consistent with the equality condition above.
- One natural sub-module: ifid_reg, holding the IF/ID pipeline register with hold and bubble controls.
- PC logic, halt detection and the counter stay in if_fetch_unit.

Test Plan:
- Reset release with ROM word0=32'h24080000 and word1=32'h24090000, no stall: cycle 1 ifid_instr=24080000, ifid_pc4=4, valid=1; cycle 2 ifid_instr=24090000, ifid_pc4=8; fetch_count=2.
- stall=1 for 3 cycles starting at pc=0x14: imem_addr stays 0x14, IF/ID unchanged, fetch_count unchanged; the cycle after release ifid_pc4=0x18.
- id_redirect=1 with id_target=0x14 at pc=0x28: next pc=0x14, ifid_valid=0, ifid_instr=0; the following cycle fetches the word at 0x14.
- Same cycle ex_redirect=1 (ex_target=0x104), id_redirect=1 (0x14) and stall=1: pc=0x104, IF/ID bubble.
- pc=0x1D4 with imem_instr=32'h08000075: IF/ID gets 08000075 with valid=1; next cycle halted=1, pc=0x1D8 and frozen; redirects ignored; ifid_valid=0 thereafter.
- Assert reset asynchronously while halted and mid-stall: all outputs return to reset values without a clock edge; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage.
//   OP_J / OP_JAL : primary opcodes of the absolute jumps
//   NOP_WORD      : instruction word used as a pipeline bubble
//   jump_target   : J-format target {pc4[31:28], idx26, 2'b00}
package mips_pkg;

  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx26);
    return {pc4[31:28], idx26, 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset         : clock, async active-low reset
//   hold               : keep current contents
//   bubble             : load BUBBLE_WORD with valid=0 (wins over hold)
//   instr_in, pc4_in   : word and PC+4 from the fetch stage
//   instr, pc4, valid  : registered IF/ID contents
module ifid_reg #(
  parameter logic [31:0] BUBBLE_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // pc4 is left untouched on a bubble; it is meaningless while valid=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= BUBBLE_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= BUBBLE_WORD;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
//   clk, reset               : clock, async active-low reset
//   imem_addr / imem_instr   : combinational instruction ROM interface
//   stall                    : hold PC and IF/ID
//   id_redirect, id_target   : jump resolved in ID
//   ex_redirect, ex_target   : taken branch resolved in EX (highest priority)
//   ifid_instr/pc4/valid     : IF/ID pipeline register
//   halted                   : sticky program-end self-jump flag
//   fetch_count              : instructions accepted into IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          HALT_DETECT = 1'b1,
  parameter logic [31:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        hold;
  logic        halt_hit;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // IF/ID control is the priority chain folded into two signals: a bubble
  // comes from halt, EX redirect, or an ID redirect that is not stalled.
  always_comb begin
    halt_hit = 1'b0;
    if (HALT_DETECT)
      halt_hit = (imem_instr[31:26] == mips_pkg::OP_J) &&
                 (mips_pkg::jump_target(pc, imem_instr[25:0]) == pc);
    bubble = halted | ex_redirect | (~stall & id_redirect);
    hold   = stall & ~bubble;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (halted) begin
      pc <= pc;
    end else if (ex_redirect) begin
      pc <= ex_target;
    end else if (stall) begin
      pc <= pc;
    end else if (id_redirect) begin
      pc <= id_target;
    end else begin
      pc          <= pc_plus4;
      fetch_count <= fetch_count + 32'd1;
      if (halt_hit)
        halted <= 1'b1;
    end
  end

  ifid_reg #(
    .BUBBLE_WORD(NOP_WORD)
  ) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .bubble   (bubble),
    .instr_in (imem_instr),
    .pc4_in   (pc_plus4),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        stall, id_redirect, ex_redirect;
  logic [31:0] id_target, ex_target;
  logic [31:0] ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid, halted;

  logic [31:0] rom [256];
  assign imem_instr = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (RST_PC),
    .HALT_DETECT(1'b1),
    .NOP_WORD   (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .id_redirect(id_redirect),
    .id_target  (id_target),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".addr"},   imem_addr,   m_pc);
    check_eq({tag, ".instr"},  ifid_instr,  m_instr);
    check_eq({tag, ".valid"},  {31'd0, ifid_valid}, {31'd0, m_valid});
    check_eq({tag, ".halted"}, {31'd0, halted},     {31'd0, m_halted});
    check_eq({tag, ".count"},  fetch_count, m_count);
    if (m_valid)
      check_eq({tag, ".pc4"}, ifid_pc4, m_pc4);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pc4 = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
  endtask

  // One clock edge of the fetch stage, from the rule list.
  task automatic model_edge();
    logic [31:0] w;
    logic [31:0] tgt;
    w = rom[(m_pc / 4) % 256];
    if (m_halted) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (ex_redirect) begin
      m_pc = ex_target; m_instr = NOP; m_valid = 1'b0;
    end else if (stall) begin
      // nothing moves
    end else if (id_redirect) begin
      m_pc = id_target; m_instr = NOP; m_valid = 1'b0;
    end else begin
      tgt = (m_pc / 32'h1000_0000) * 32'h1000_0000 + (w % 32'h0400_0000) * 4;
      if ((w / 32'h0400_0000) == 2 && tgt == m_pc) m_halted = 1'b1;
      m_instr = w; m_valid = 1'b1;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic drive(input logic s, input logic idr, input logic [31:0] idt,
                       input logic exr, input logic [31:0] ext);
    stall = s; id_redirect = idr; id_target = idt;
    ex_redirect = exr; ex_target = ext;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_until(input logic [31:0] target_pc);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 64 && m_pc != target_pc; i++) step("walk");
    check_eq("walk_reached", imem_addr, target_pc);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i][31:26] == 6'b000010) rom[i][31:26] = 6'b001001;
    end
    rom[0]   = 32'h2408_0000;
    rom[1]   = 32'h2409_0000;
    rom[128] = 32'h0C00_0080;   // jal to itself at 0x200
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk) reset = 1'b1;

    // Straight-line fetch
    step("tp1a");
    check_eq("tp1_w0", ifid_instr, 32'h2408_0000);
    check_eq("tp1_pc4a", ifid_pc4, 32'd4);
    step("tp1b");
    check_eq("tp1_w1", ifid_instr, 32'h2409_0000);
    check_eq("tp1_cnt", fetch_count, 32'd2);

    // Stall for three cycles at 0x14
    idle_until(32'h14);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("stall");
    check_eq("stall_addr", imem_addr, 32'h14);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("unstall");
    check_eq("unstall_pc4", ifid_pc4, 32'h18);

    // ID redirect at 0x28
    idle_until(32'h28);
    drive(1'b0, 1'b1, 32'h14, 1'b0, '0);
    step("idr");
    check_eq("idr_addr", imem_addr, 32'h14);
    check_eq("idr_valid", {31'd0, ifid_valid}, 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("idr_next");
    check_eq("idr_fetch", ifid_instr, rom[5]);

    // EX redirect beats stall and ID redirect
    drive(1'b1, 1'b1, 32'h14, 1'b1, 32'h104);
    step("exr_all");
    check_eq("exr_addr", imem_addr, 32'h104);

    // PC wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    step("wrap_redir");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("wrap");
    check_eq("wrap_addr", imem_addr, 32'h0);

    // jal self-jump must not halt
    drive(1'b0, 1'b1, 32'h200, 1'b0, '0);
    step("jal_redir");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("jal_fetch");
    step("jal_after");
    check_eq("jal_nohalt", {31'd0, halted}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, (i % 97 == 0) ? $urandom : ($urandom & 32'h3FF),
            $urandom_range(0, 7) == 0, $urandom & 32'h3FF);
      step("rand");
    end

    // Program-end self-jump at 0x1D4
    rom[117] = 32'h0800_0075;
    drive(1'b0, 1'b1, 32'h1D4, 1'b0, '0);
    step("halt_redir");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    step("halt_fetch");
    check_eq("halt_word", ifid_instr, 32'h0800_0075);
    check_eq("halt_wvalid", {31'd0, ifid_valid}, 32'd1);
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    step("halt_bubble");
    check_eq("halt_addr", imem_addr, 32'h1D8);
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 1) == 1, 1'b1, $urandom & 32'h3FF, 1'b1, $urandom & 32'h3FF);
      step("halt_frozen");
    end
    check_eq("frozen_addr", imem_addr, 32'h1D8);

    // Asynchronous reset while halted
    #3 reset = 1'b0;
    #1 model_reset();
    check_state("async_halt");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk) reset = 1'b1;
    step("restart");
    check_eq("restart_pc4", ifid_pc4, RST_PC + 32'd4);

    // Asynchronous reset mid-stall with a pending redirect
    drive(1'b1, 1'b1, 32'h80, 1'b0, '0);
    step("pend1");
    step("pend2");
    #3 reset = 1'b0;
    #1 model_reset();
    check_state("async_stall");
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk) reset = 1'b1;
    step("post_rst1");
    step("post_rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
